// File: rtl/result_demux_pkg.sv
// Shared constants and the destination decode for the result_demux3 router.
package result_demux_pkg;

    localparam logic [1:0] SEL_P0  = 2'b00;
    localparam logic [1:0] SEL_P1  = 2'b01;
    localparam logic [1:0] SEL_P2  = 2'b10;
    localparam logic [1:0] SEL_RSV = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    // Same mapping as the 3:1 operand select: anything above 01 lands on port 2.
    function automatic logic [2:0] sel_decode(input logic [1:0] sel);
        logic [2:0] onehot;
        case (sel)
            SEL_P0:  onehot = 3'b001;
            SEL_P1:  onehot = 3'b010;
            default: onehot = 3'b100;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/result_demux3_skid_buf2.sv
// Two-entry in-order buffer; e0 is always the head. The occupancy FSM state is
// exported directly so checkers can bind to it.
module skid_buf2
    import result_demux_pkg::*;
#(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output occ_e         state
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        e0    <= din;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        e0 <= din;
                    end else if (push) begin
                        e1    <= din;
                        state <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // The top holds in_ready low when full, so only a pop can happen here.
                    if (pop) begin
                        e0    <= e1;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign dout = e0;

endmodule

// File: rtl/result_demux3.sv
// Registered 1-to-3 result router. Optional macro RESULT_DEMUX_RSV_SEL_DROP_EN
// drops sel=11 results on accept and flags them on a sticky sel_err output.
module result_demux3
    import result_demux_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_ready,
    output logic [1:0]        occupancy
`ifdef RESULT_DEMUX_RSV_SEL_DROP_EN
    ,
    output logic              sel_err
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready depends only on registered state and rst; out_valid is
    // held stable until the targeted sink's ready bit is high.

    localparam int EW = DATA_W + 2;

    logic          push;
    logic          store;
    logic          pop;
    logic [EW-1:0] head;
    logic [1:0]    head_sel;
    logic [DATA_W-1:0] head_data;
    occ_e          state;
    logic          nonempty;

    assign in_ready = ~rst & (state != TWO);
    assign push     = in_valid & in_ready;

`ifdef RESULT_DEMUX_RSV_SEL_DROP_EN
    assign store = push & (in_sel != SEL_RSV);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (push && (in_sel == SEL_RSV)) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign store = push;
`endif

    skid_buf2 #(.W(EW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (store),
        .pop   (pop),
        .din   ({in_sel, in_data}),
        .dout  (head),
        .state (state)
    );

    assign head_sel  = head[EW-1 -: 2];
    assign head_data = head[DATA_W-1:0];
    assign nonempty  = (state != EMPTY);

    assign out_valid = nonempty ? sel_decode(head_sel) : 3'b000;
    assign out_data  = nonempty ? head_data : '0;
    assign pop       = |(out_valid & out_ready);
    assign occupancy = state;

endmodule

// File: doc/result_demux3.md
Name: result_demux3

Overview:
- Registered 1-to-3 result router. It is the distribution counterpart of the 3:1 writeback/operand select.
- Accepts one 32-bit result plus a 2-bit destination select over a valid/ready handshake and delivers it to exactly one of three sinks, strictly in order.
- A 2-entry buffer gives full throughput and registers all outputs.
- Sits between the execute stage and the three consumers: register-file write port, memory store path, forwarding/branch unit.

Parameters:
- DATA_W, 32, width of in_data/out_data.

Ports:
- clk  input  1  sole clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a result
- in_ready  output  1  block can accept this cycle
- in_data  input  DATA_W  result value
- in_sel  input  2  destination: 00→port0, 01→port1, 10/11→port2
- out_data  output  DATA_W  head-entry data, shared by all three sinks
- out_valid  output  3  one-hot; bit k = head entry is for sink k
- out_ready  input  3  per-sink ready
- occupancy  output  2  entries held (0..2)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - occupancy=0, out_valid=3'b000, out_data=0, buffer entries cleared.
  - in_ready=0 while rst is high, 1 on the first cycle after release.
- Accept: push = in_valid & in_ready. {sel,data} are captured at the edge.
- Ready: in_ready = ~rst & (occupancy != 2). It is a pure function of registered state, with no combinational path from out_ready.
- Latency: a pushed item appears on out_data/out_valid the cycle after the accept edge (1 cycle) if the buffer was empty.
- Head:
  - out_valid[k]=1 only when occupancy>0 and the head's decoded sel equals k. At most one bit is set.
  - out_data = head data when occupancy>0, else 0.
- Pop: pop = |(out_valid & out_ready). Ready bits of sinks not targeted are ignored.
- States (occupancy):
  - EMPTY: push→ONE.
  - ONE: push&~pop→TWO; pop&~push→EMPTY; push&pop→ONE, second entry becomes head.
  - TWO: pop→ONE; push is impossible because in_ready=0.
- Ordering: strict FIFO, head-of-line blocking. A stalled sink blocks items for other sinks.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data and out_valid hold unchanged.
- Sel decode: matches the 3:1 select. 00→0, 01→1, any other value→2.
- Reset mid-operation: buffered entries are discarded with no delivery. out_valid drops to 0 in the cycle after the rst edge.
- Throughput: one item per cycle sustained when the target sink is ready.

Optional Feature:
- Macro: RESULT_DEMUX_RSV_SEL_DROP_EN.
- With the macro defined:
  - in_sel=11 is accepted normally (in_ready unaffected) but not stored. Occupancy is unchanged.
  - Added output sel_err (1 bit) is set sticky on such an accept and cleared only by rst.
- Without the macro: 11 routes to port2, identical to 10. The sel_err port does not exist.

Decomposition:
- Package result_demux_pkg holds:
  - sel constants SEL_P0=2'b00, SEL_P1=2'b01, SEL_P2=2'b10, SEL_RSV=2'b11
  - occupancy state constants EMPTY/ONE/TWO
  - decode function sel→one-hot[2:0]
- One natural sub-module: skid_buf2, a 2-entry in-order buffer of {sel,data} with push/pop/occupancy.
- The top level adds the sel decode, output gating and optional drop logic.

Test Plan:
- Reset/idle: hold rst 3 cycles with in_valid=1 → in_ready=0, out_valid=000, occupancy=0. After release, in_ready=1.
- Single route: push data=32'hDEADBEEF, sel=01, out_ready=111 → next cycle out_valid=010, out_data=DEADBEEF. One cycle later out_valid=000.
- Full/backpressure: out_ready=000, push A=1 (sel 00) then B=2 (sel 10) → occupancy=2, in_ready=0, out_valid=001, out_data=1, held 5 cycles. Raise out_ready=001 → A pops. Next out_valid=100, out_data=2.
- HOL blocking: head sel=10 with out_ready=011 → no pop, occupancy stays, second entry (sel 00) not presented.
- Streaming: 8 back-to-back pushes, sel cycling 00,01,10,11, out_ready=111 → one delivery per cycle, in order, sel 11 on port2 (macro off). With macro on, the 11 items are absent and sel_err=1.
- Reset mid-flight: occupancy=2, assert rst 1 cycle → next cycle occupancy=0, out_valid=000. No stale data delivered after release.
